ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: the send side of the keyboard link whose receive path feeds the character buffer.

---
 rtl/ps2_host_tx_if.sv | 30 +++
 rtl/ps2_host_tx.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte request/status bundle for the PS/2 host transmitter
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_err,
        input  timeout_err
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output busy,
        output done,
        output ack_err,
        output timeout_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with ACK check (optional retry: PS2_TX_RETRY_EN)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int FRAME_TIMEOUT  = 200000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic             clk,
    input  logic             reset,
    ps2_host_tx_if.slave     tx_if,
    input  logic             ps2_clk_i,
    input  logic             ps2_data_i,
    output logic             ps2_clk_oe,
    output logic             ps2_data_oe
);

`ifdef PS2_TX_RETRY_EN
    localparam int RETRY_LIMIT = MAX_RETRIES;
`else
    localparam int RETRY_LIMIT = 0;
`endif

    // One shared cycle counter serves inhibit, start wait, frame wait and retry back-off;
    // one spare code above the largest limit keeps saturation from ever matching a limit.
    localparam int CNT_MAX0 = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
    localparam int CNT_MAX  = (CNT_MAX0 > FRAME_TIMEOUT) ? CNT_MAX0 : FRAME_TIMEOUT;
    localparam int CW       = $clog2(CNT_MAX + 2);
    localparam int RW       = $clog2(MAX_RETRIES + 2);

    localparam logic [CW-1:0] C_INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] C_INH_PRE  = CW'(INHIBIT_CYCLES - 2);
    localparam logic [CW-1:0] C_START_TO = CW'(START_TIMEOUT);
    localparam logic [CW-1:0] C_FRAME_TO = CW'(FRAME_TIMEOUT);
    localparam logic [RW-1:0] C_RETRIES  = RW'(RETRY_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_DATA,
        S_ACK,
        S_WAIT_IDLE,
        S_FAIL,
        S_RETRY_WAIT
    } state_t;

    state_t          r_state;
    logic [2:0]      r_clk_sync;
    logic [1:0]      r_data_sync;
    logic [7:0]      r_byte;
    logic [8:0]      r_shift;
    logic [3:0]      r_bitn;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_attempt;
    logic            r_fail_to;
    logic            r_ready;
    logic            r_busy;
    logic            r_done;
    logic            r_ack_err;
    logic            r_timeout_err;
    logic            r_clk_oe;
    logic            r_data_oe;

    logic            w_clk_fall;
    logic            w_clk_hi;
    logic            w_data_hi;
    logic [CW-1:0]   w_cnt_inc;

    assign w_clk_hi   = r_clk_sync[1];
    assign w_data_hi  = r_data_sync[1];
    assign w_clk_fall = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    // Two-flop synchronisers for the raw lines plus a delayed clock copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], ps2_clk_i};
            r_data_sync <= {r_data_sync[0], ps2_data_i};
        end
    end

    // Transmit sequencer: inhibit, request-to-send, device-clocked data/parity/stop, ACK, status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_byte        <= 8'h00;
            r_shift       <= 9'h1FF;
            r_bitn        <= 4'd0;
            r_cnt         <= '0;
            r_attempt     <= '0;
            r_fail_to     <= 1'b0;
            r_ready       <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_ack_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_clk_oe      <= 1'b0;
            r_data_oe     <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_ack_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_if.tx_valid && r_ready) begin
                        r_byte    <= tx_if.tx_data;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_clk_oe  <= 1'b1;
                        r_cnt     <= '0;
                        r_attempt <= '0;
                        r_state   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    // Data is pulled low one cycle before the clock is released so the
                    // device sees a clean request-to-send.
                    if (r_cnt == C_INH_LAST) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b1;
                        r_shift   <= {~^r_byte, r_byte};
                        r_bitn    <= 4'd0;
                        r_cnt     <= '0;
                        r_state   <= S_REQ;
                    end else begin
                        if (r_cnt == C_INH_PRE) begin
                            r_data_oe <= 1'b1;
                        end
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_REQ: begin
                    // First device falling edge: present data bit 0.
                    if (w_clk_fall) begin
                        r_data_oe <= ~r_shift[0];
                        r_shift   <= {1'b1, r_shift[8:1]};
                        r_bitn    <= 4'd1;
                        r_cnt     <= '0;
                        r_state   <= S_DATA;
                    end else if (r_cnt >= C_START_TO) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_fail_to <= 1'b1;
                        r_state   <= S_FAIL;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DATA: begin
                    // Ones are shifted in behind the frame, so the tenth edge presents
                    // a 1 and releases the line for the stop bit.
                    if (r_cnt >= C_FRAME_TO) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_fail_to <= 1'b1;
                        r_state   <= S_FAIL;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_clk_fall) begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b1, r_shift[8:1]};
                            r_bitn    <= r_bitn + 4'd1;
                            if (r_bitn == 4'd9) begin
                                r_state <= S_ACK;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (r_cnt >= C_FRAME_TO) begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_fail_to <= 1'b1;
                        r_state   <= S_FAIL;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_clk_fall) begin
                            if (w_data_hi) begin
                                r_fail_to <= 1'b0;
                                r_state   <= S_FAIL;
                            end else begin
                                r_state <= S_WAIT_IDLE;
                            end
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_clk_hi && w_data_hi) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_FAIL: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (r_attempt < C_RETRIES) begin
                        r_attempt <= r_attempt + 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_RETRY_WAIT;
                    end else begin
                        r_timeout_err <= r_fail_to;
                        r_ack_err     <= ~r_fail_to;
                        r_busy        <= 1'b0;
                        r_ready       <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                S_RETRY_WAIT: begin
                    // Lines stay released for one inhibit period before the next attempt.
                    if (r_cnt == C_INH_LAST) begin
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b1;
                        r_state  <= S_INHIBIT;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ready   <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_if.tx_ready    = r_ready;
    assign tx_if.busy        = r_busy;
    assign tx_if.done        = r_done;
    assign tx_if.ack_err     = r_ack_err;
    assign tx_if.timeout_err = r_timeout_err;
    assign ps2_clk_oe        = r_clk_oe;
    assign ps2_data_oe       = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized bench for ps2_host_tx against a PS/2 device model
module tb_ps2_host_tx;
    localparam int INH = 40;
    localparam int ST  = 400;
    localparam int FT  = 600;
    localparam int MR  = 2;
`ifdef PS2_TX_RETRY_EN
    localparam int ATT = MR + 1;
`else
    localparam int ATT = 1;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    wire  ps2_clk_oe;
    wire  ps2_data_oe;
    wire  clk_line  = ps2_clk_oe  ? 1'b0 : dev_clk;
    wire  data_line = ps2_data_oe ? 1'b0 : dev_data;

    always #5 clk = ~clk;

    ps2_host_tx_if tx_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST),
        .FRAME_TIMEOUT  (FT),
        .MAX_RETRIES    (MR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_if       (tx_if),
        .ps2_clk_i   (clk_line),
        .ps2_data_i  (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Passive monitor: status pulse counts, inhibit phase count/length, request and timeout times.
    int   cyc = 0, n_done = 0, n_ack = 0, n_to = 0, n_multi = 0;
    int   n_inh = 0, inh_run = 0, last_inh_len = 0, last_req_cyc = 0, last_to_cyc = 0;
    logic prev_clk_oe = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_if.done)        n_done <= n_done + 1;
        if (tx_if.ack_err)     n_ack  <= n_ack + 1;
        if (tx_if.timeout_err) begin
            n_to        <= n_to + 1;
            last_to_cyc <= cyc;
        end
        if (int'(tx_if.done) + int'(tx_if.ack_err) + int'(tx_if.timeout_err) > 1) n_multi <= n_multi + 1;
        if (ps2_clk_oe) begin
            inh_run <= inh_run + 1;
        end else if (prev_clk_oe) begin
            n_inh        <= n_inh + 1;
            last_inh_len <= inh_run;
            inh_run      <= 0;
            if (ps2_data_oe) last_req_cyc <= cyc;
        end
        prev_clk_oe <= ps2_clk_oe;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int w = 0;
        int hold;
        while (!tx_if.tx_ready && w < 1000) begin step(); w++; end
        check_eq("ready_before_send", tx_if.tx_ready, 1);
        hold = $urandom_range(1, 3);
        tx_if.tx_data  = b;
        tx_if.tx_valid = 1'b1;
        step();
        check_eq("busy_after_accept", tx_if.busy, 1);
        check_eq("ready_after_accept", tx_if.tx_ready, 0);
        for (int i = 1; i < hold; i++) begin
            tx_if.tx_data = 8'($urandom);
            step();
        end
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'($urandom);
    endtask

    // Device side: wait for request-to-send, then generate n_edges clock pulses,
    // reading the line just before each rising edge; pull data low before edge 11 when ACKing.
    task automatic dev_frame(input int n_edges, input logic ack_lvl,
                             output logic [9:0] bits, output logic start_bit, output bit got_req);
        int w = 0;
        int hp;
        bits = '1;
        start_bit = 1'b1;
        got_req = 1'b0;
        while (!ps2_clk_oe && w < 5000) begin step(); w++; end
        while (ps2_clk_oe && w < 5000) begin step(); w++; end
        got_req = (w < 5000) && !ps2_clk_oe && ps2_data_oe;
        if (!got_req || n_edges == 0) return;
        repeat ($urandom_range(5, 30)) step();
        start_bit = data_line;
        hp = $urandom_range(8, 20);
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11) begin
                dev_data = ack_lvl;
                repeat (3) step();
            end
            dev_clk = 1'b0;
            repeat (hp) step();
            if (k <= 10) bits[k-1] = data_line;
            dev_clk = 1'b1;
            repeat (hp) step();
        end
        dev_data = 1'b1;
    endtask

    // One accepted byte; acks[a] is the level the device returns on attempt a.
    task automatic run_case(input string name, input logic [7:0] b, input int n_edges, input logic [2:0] acks);
        int       used;
        bit       exp_done;
        logic     par;
        logic [9:0] exp_frame, bits;
        logic     sb;
        bit       got;
        int       d0, a0, t0, i0, w;
        used = ATT;
        exp_done = 1'b0;
        if (n_edges == 11) begin
            for (int a = 0; a < ATT; a++) begin
                if (!exp_done && !acks[a]) begin
                    exp_done = 1'b1;
                    used = a + 1;
                end
            end
        end
        par = ($countones(b) % 2 == 0);
        exp_frame = {1'b1, par, b};
        d0 = n_done; a0 = n_ack; t0 = n_to; i0 = n_inh;
        send(b);
        for (int a = 0; a < used; a++) begin
            dev_frame(n_edges, acks[a], bits, sb, got);
            check_eq({name, "_request"}, got, 1);
            if (n_edges == 11) begin
                check_eq({name, "_start_bit"}, sb, 0);
                check_eq({name, "_frame_bits"}, bits, exp_frame);
            end
        end
        w = 0;
        while ((n_done + n_ack + n_to) == (d0 + a0 + t0) && w < 3000) begin step(); w++; end
        check_eq({name, "_status_seen"}, (w < 3000), 1);
        check_eq({name, "_done"}, n_done - d0, exp_done ? 1 : 0);
        check_eq({name, "_ack_err"}, n_ack - a0, (!exp_done && n_edges == 11) ? 1 : 0);
        check_eq({name, "_timeout"}, n_to - t0, (n_edges != 11) ? 1 : 0);
        check_eq({name, "_inhibit_phases"}, n_inh - i0, used);
        check_eq({name, "_inhibit_len"}, last_inh_len, INH);
        if (n_edges == 0)
            check_eq({name, "_start_to_window"},
                     ((last_to_cyc - last_req_cyc) >= ST) && ((last_to_cyc - last_req_cyc) <= ST + 4), 1);
        step();
        check_eq({name, "_ready_after"}, tx_if.tx_ready, 1);
        check_eq({name, "_busy_after"}, tx_if.busy, 0);
        check_eq({name, "_oe_after"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
    endtask

    initial begin
        logic [9:0] bits;
        logic       sb;
        bit         got;
        int         s0;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        repeat (4) step();
        check_eq("reset_ready", tx_if.tx_ready, 1);
        check_eq("reset_busy", tx_if.busy, 0);
        check_eq("reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check_eq("reset_pulses", {tx_if.done, tx_if.ack_err, tx_if.timeout_err}, 3'b000);
        reset = 1'b1;
        repeat (3) step();

        run_case("ed", 8'hED, 11, 3'b000);
        run_case("f4", 8'hF4, 11, 3'b000);
        run_case("ack_high", 8'($urandom), 11, 3'b111);
        run_case("no_clock", 8'($urandom), 0, 3'b111);
        run_case("stall", 8'($urandom), 5, 3'b000);

        // Reset in the middle of a frame releases both lines at once.
        s0 = n_done + n_ack + n_to;
        send(8'h5A);
        dev_frame(4, 1'b0, bits, sb, got);
        check_eq("rst_mid_request", got, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check_eq("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check_eq("rst_mid_busy", tx_if.busy, 0);
        check_eq("rst_mid_ready", tx_if.tx_ready, 1);
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();
        check_eq("rst_mid_no_status", n_done + n_ack + n_to, s0);

        run_case("p01", 8'h01, 11, 3'b000);
        run_case("retry_ok", 8'($urandom), 11, 3'b011);

        for (int i = 0; i < 6; i++) begin
            logic [2:0] acks;
            acks = 3'($urandom) & 3'($urandom);
            run_case($sformatf("rnd%0d", i), 8'($urandom), 11, acks);
        end

        check_eq("single_status_per_cycle", n_multi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, total=%0d", total);
        $fatal(1, "watchdog expired");
    end
endmodule
